// File: rtl/kfps2kb_keycode_fifo_pkg.sv
// Shared types and constants for the PS/2-to-XT keycode FIFO.
package kfps2kb_pkg;

  typedef logic [7:0] keycode_t;

  localparam keycode_t KEYCODE_OVERRUN = 8'hFF;
  localparam keycode_t KEYCODE_NONE    = 8'h00;

  typedef enum logic {
    CAP_IDLE,
    CAP_ACK
  } cap_state_t;

  typedef enum logic [1:0] {
    OUT_EMPTY,
    OUT_PRESENT,
    OUT_CLEAR
  } out_state_t;

endpackage

// File: rtl/kfps2kb_keycode_fifo_ram.sv
// DEPTH x 8 keycode storage: one synchronous write port, asynchronous read, no reset.
module kfps2kb_keycode_ram
  import kfps2kb_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  keycode_t                 wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output keycode_t                 rdata
);

  keycode_t mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/kfps2kb_keycode_fifo.sv
// Keycode FIFO between the PS/2 scancode converter and the XT PPI/interrupt side.
// Option: KFPS2KB_OVERRUN_CODE_EN replaces the newest entry with 8'hFF on a full push.
module kfps2kb_keycode_fifo
  import kfps2kb_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in_irq,
  input  logic [7:0] in_keycode,
  output logic       in_clear,
  output logic       out_irq,
  output logic [7:0] out_keycode,
  input  logic       out_clear,
  output logic       overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  cap_state_t    cap_state;
  out_state_t    out_state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          avail;

  logic          push_req;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic          push_over;
  logic          ram_we;
  logic [PW-1:0] ram_waddr;
  keycode_t      ram_wdata;
  keycode_t      head;

  always_comb begin
    push_req  = (cap_state == CAP_IDLE) && in_irq;
    pop       = (out_state == OUT_EMPTY) && avail && !out_clear;
    full      = (count == FULL_COUNT);
    push_ok   = push_req && (!full || pop);
    push_over = push_req && full && !pop;
    ram_we    = push_ok;
    ram_waddr = wr_ptr;
    ram_wdata = in_keycode;
`ifdef KFPS2KB_OVERRUN_CODE_EN
    if (push_over) begin
      ram_we    = 1'b1;
      ram_waddr = wr_ptr - PW'(1);
      ram_wdata = KEYCODE_OVERRUN;
    end
`endif
  end

  kfps2kb_keycode_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cap_state   <= CAP_IDLE;
      out_state   <= OUT_EMPTY;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      avail       <= 1'b0;
      in_clear    <= 1'b0;
      out_irq     <= 1'b0;
      out_keycode <= KEYCODE_NONE;
      overflow    <= 1'b0;
    end else begin
      in_clear <= 1'b0;
      case (cap_state)
        CAP_IDLE: begin
          if (in_irq) begin
            cap_state <= CAP_ACK;
            in_clear  <= 1'b1;
          end
        end
        CAP_ACK:  cap_state <= CAP_IDLE;
        default:  cap_state <= CAP_IDLE;
      endcase

      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // Registered non-empty flag gives the capture-to-irq latency of two edges;
      // it can only be stale right after a pop, when the output FSM has left OUT_EMPTY.
      avail <= (count != '0);

      case (out_state)
        OUT_EMPTY: begin
          if (out_clear) begin
            out_state <= OUT_CLEAR;
          end else if (avail) begin
            out_keycode <= head;
            out_irq     <= 1'b1;
            out_state   <= OUT_PRESENT;
          end
        end
        OUT_PRESENT: begin
          if (out_clear) begin
            out_irq     <= 1'b0;
            out_keycode <= KEYCODE_NONE;
            overflow    <= 1'b0;
            out_state   <= OUT_CLEAR;
          end
        end
        OUT_CLEAR: begin
          if (!out_clear) out_state <= OUT_EMPTY;
        end
        default: out_state <= OUT_EMPTY;
      endcase

      // A new overrun in the same cycle as the clear wins, so it is never lost.
      if (push_over) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_kfps2kb_keycode_fifo.sv
// Scoreboard bench for kfps2kb_keycode_fifo with DEPTH=4.
module tb_kfps2kb_keycode_fifo;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       in_irq;
  logic [7:0] in_keycode;
  logic       in_clear;
  logic       out_irq;
  logic [7:0] out_keycode;
  logic       out_clear;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  logic prev_irq = 1'b0;
  int   low_cnt  = 100;

  kfps2kb_keycode_fifo #(
    .DEPTH (4)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_irq      (in_irq),
    .in_keycode  (in_keycode),
    .in_clear    (in_clear),
    .out_irq     (out_irq),
    .out_keycode (out_keycode),
    .out_clear   (out_clear),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rising out_irq must present the next expected keycode after a low gap >= 2.
  always @(negedge clock) begin
    if (out_irq && !prev_irq) begin
      chk("irq_low_gap", 32'(low_cnt >= 2), 32'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_irq", 32'(out_keycode), 32'hFFFF_FFFF);
      end else begin
        chk("keycode_order", 32'(out_keycode), 32'(exp_q.pop_front()));
      end
    end
    low_cnt  = out_irq ? 0 : low_cnt + 1;
    prev_irq = out_irq;
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Converter model: irq held until one edge after in_clear is seen.
  task automatic send(input logic [7:0] code);
    in_irq     = 1'b1;
    in_keycode = code;
    tick();
    tick();
    in_irq = 1'b0;
  endtask

  task automatic wait_irq();
    for (int i = 0; i < 20 && !out_irq; i++) tick();
    chk("irq_wait", 32'(out_irq), 32'd1);
  endtask

  task automatic clear_once();
    out_clear = 1'b1;
    tick();
    chk("clear_irq_low", 32'(out_irq), 32'd0);
    chk("clear_code_none", 32'(out_keycode), 32'h00);
    tick();
    out_clear = 1'b0;
    tick();
    chk("post_clear_gap", 32'(out_irq), 32'd0);
  endtask

  task automatic deliver();
    wait_irq();
    clear_once();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_clear"},    32'(in_clear),    32'd0);
    chk({tag, "_out_irq"},     32'(out_irq),     32'd0);
    chk({tag, "_out_keycode"}, 32'(out_keycode), 32'h00);
    chk({tag, "_overflow"},    32'(overflow),    32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    in_irq     = 1'b0;
    in_keycode = 8'h00;
    out_clear  = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    tick();

    // Single key: clear pulse one edge after capture, irq two edges after capture
    exp_q.push_back(8'h1E);
    in_irq     = 1'b1;
    in_keycode = 8'h1E;
    tick();
    chk("single_in_clear_hi", 32'(in_clear), 32'd1);
    chk("single_irq_n1", 32'(out_irq), 32'd0);
    tick();
    in_irq = 1'b0;
    chk("single_in_clear_lo", 32'(in_clear), 32'd0);
    chk("single_irq_n2", 32'(out_irq), 32'd0);
    tick();
    chk("single_irq_hi", 32'(out_irq), 32'd1);
    chk("single_code", 32'(out_keycode), 32'h1E);
    out_clear = 1'b1;
    repeat (3) tick();
    chk("single_cleared_irq", 32'(out_irq), 32'd0);
    chk("single_cleared_code", 32'(out_keycode), 32'h00);
    out_clear = 1'b0;
    repeat (4) tick();
    chk("single_no_dup", 32'(out_irq), 32'd0);

    // Burst while clear held: nothing presented until release, then in order
    out_clear = 1'b1;
    tick();
    foreach (exp_q[i]) chk("burst_q_empty", 32'd1, 32'd0);
    exp_q.push_back(8'h1E); send(8'h1E);
    exp_q.push_back(8'h9E); send(8'h9E);
    exp_q.push_back(8'h30); send(8'h30);
    repeat (3) tick();
    chk("burst_held", 32'(out_irq), 32'd0);
    out_clear = 1'b0;
    tick();
    chk("burst_release_gap", 32'(out_irq), 32'd0);
    repeat (3) deliver();

    // Full FIFO: fifth push overflows
    out_clear = 1'b1;
    tick();
    exp_q.push_back(8'h11); send(8'h11);
    exp_q.push_back(8'h22); send(8'h22);
    exp_q.push_back(8'h33); send(8'h33);
`ifdef KFPS2KB_OVERRUN_CODE_EN
    exp_q.push_back(8'hFF); send(8'h44);
`else
    exp_q.push_back(8'h44); send(8'h44);
`endif
    chk("full_no_ovf_yet", 32'(overflow), 32'd0);
    send(8'h55);
    chk("full_ovf_set", 32'(in_clear), 32'd0);
    chk("full_ovf", 32'(overflow), 32'd1);
    out_clear = 1'b0;
    tick();
    wait_irq();
    chk("ovf_sticky", 32'(overflow), 32'd1);
    clear_once();
    chk("ovf_cleared", 32'(overflow), 32'd0);
    repeat (3) deliver();

    // Push with same-cycle pop at count=DEPTH, pointers wrapping
    out_clear = 1'b1;
    tick();
    exp_q.push_back(8'hA1); send(8'hA1);
    exp_q.push_back(8'hA2); send(8'hA2);
    exp_q.push_back(8'hA3); send(8'hA3);
    exp_q.push_back(8'hA4); send(8'hA4);
    out_clear = 1'b0;
    tick();
    exp_q.push_back(8'hA5);
    in_irq     = 1'b1;
    in_keycode = 8'hA5;
    tick();
    chk("pushpop_irq", 32'(out_irq), 32'd1);
    chk("pushpop_in_clear", 32'(in_clear), 32'd1);
    tick();
    in_irq = 1'b0;
    chk("pushpop_no_ovf", 32'(overflow), 32'd0);
    repeat (5) deliver();
    chk("pushpop_no_ovf_end", 32'(overflow), 32'd0);

    // Reset during OUT_PRESENT with two codes queued
    out_clear = 1'b1;
    tick();
    exp_q.push_back(8'hB1); send(8'hB1);
    send(8'hB2);
    send(8'hB3);
    out_clear = 1'b0;
    tick();
    wait_irq();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk_reset_outputs("midreset");
    chk("midreset_b1_seen", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (10) tick();
    chk("midreset_no_irq", 32'(out_irq), 32'd0);
    exp_q.push_back(8'hFF);
    send(8'hFF);
    deliver();

    repeat (4) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/kfps2kb_keycode_fifo.md
KFPS2KB_KEYCODE_FIFO -- requirements
Module: kfps2kb_keycode_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, keycode entries buffered; power of two, 2..256.
REQ-002 SHALL have port clock  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset_n  in  1  reset; synchronous, active-low.
REQ-004 SHALL have port in_irq  in  1  keycode-valid from the PS/2 scancode converter.
REQ-005 SHALL have port in_keycode  in  8  converted XT keycode from the converter.
REQ-006 SHALL have port in_clear  out  1  clear_keycode pulse back to the converter.
REQ-007 SHALL have port out_irq  out  1  keyboard interrupt request to the interrupt controller / PPI.
REQ-008 SHALL have port out_keycode  out  8  keycode presented to the PPI port A.
REQ-009 SHALL have port out_clear  in  1  PPI keyboard-clear bit; level, any duration.
REQ-010 SHALL have port overflow  out  1  sticky overrun flag.

Function
REQ-011 Capture FSM SHALL have states CAP_IDLE and CAP_ACK.
- CAP_IDLE with in_irq=1: push in_keycode, go to CAP_ACK.
- CAP_ACK: in_clear=1 for exactly that cycle, ignore in_irq, return to CAP_IDLE.
REQ-012 Given the converter's one-cycle clear latency, each in_irq assertion SHALL be captured exactly once.
REQ-013 Storage SHALL be circular: rd_ptr/wr_ptr of clog2(DEPTH) bits wrapping DEPTH-1 -> 0; count of clog2(DEPTH)+1 bits, range 0..DEPTH.
REQ-014 Full (count==DEPTH) push SHALL follow the Configuration rules; a push with a same-cycle pop SHALL succeed with count unchanged.
REQ-015 Output FSM SHALL have states OUT_EMPTY, OUT_PRESENT and OUT_CLEAR.
- OUT_EMPTY with count>0 and out_clear=0: pop head into out_keycode, out_irq=1, go to OUT_PRESENT.
- OUT_PRESENT: hold out_irq/out_keycode stable; on out_clear=1, out_irq=0, out_keycode=8'h00, go to OUT_CLEAR.
- OUT_CLEAR: remain while out_clear=1; on out_clear=0 go to OUT_EMPTY.
REQ-016 Latency SHALL be as follows: FIFO empty, output idle, in_irq sampled high at edge N -> out_irq high after edge N+2.
REQ-017 After out_clear deasserts, the next queued code SHALL be presented no earlier than 2 edges later, guaranteeing an irq low gap of at least 2 cycles.
REQ-018 out_clear=1 in OUT_EMPTY SHALL move to OUT_CLEAR, with no pop.
REQ-019 out_clear SHALL NOT discard queued entries.
REQ-020 overflow SHALL set on any dropped or replaced push and SHALL clear on the OUT_PRESENT -> OUT_CLEAR transition.
REQ-021 Keycode 8'hFF (converter error code) SHALL be queued as an ordinary code.

Reset
REQ-022 reset_n=0 at an edge SHALL force the following:
- CAP_IDLE, OUT_EMPTY;
- pointers and count 0;
- in_clear=0, out_irq=0, out_keycode=8'h00, overflow=0.
REQ-023 Reset mid-handshake SHALL discard all queued and presented codes; storage contents need not be cleared.

Configuration
REQ-024 Macro KFPS2KB_OVERRUN_CODE_EN SHALL be the only compile-time option.
- Defined: a push into a full FIFO overwrites the newest entry with 8'hFF (overrun code), so the host sees the overrun in order; count unchanged.
- Undefined: the push is dropped and storage is unchanged.
- In both cases in_clear is still pulsed and overflow is set.

Structure
REQ-025 Shared package kfps2kb_pkg SHALL hold the following:
- keycode_t (8-bit);
- KEYCODE_OVERRUN=8'hFF and KEYCODE_NONE=8'h00;
- the cap_state_t and out_state_t enums.
REQ-026 Storage SHALL be a sub-module kfps2kb_keycode_ram: DEPTH x 8, one write port, asynchronous read at rd_ptr, no reset.

Verification
REQ-027 Single key: in_irq=1, in_keycode=8'h1E.
- Expected: in_clear pulses 1 cycle, 1 edge later.
- Expected: out_irq=1 with out_keycode=8'h1E, 2 edges after capture.
- out_clear=1 for 3 cycles -> out_irq=0, out_keycode=8'h00.
REQ-028 Burst: push 8'h1E, 8'h9E, 8'h30 while out_clear is held high.
- Release out_clear -> codes presented in order.
- Each presentation needs its own clear; irq low gap of at least 2 cycles each time.
REQ-029 Full, macro undefined: DEPTH=4, push 5 codes with no clear.
- Expected: overflow=1; codes 1..4 delivered; fifth lost.
- Expected: overflow clears at the first clear.
REQ-030 Full, macro defined: DEPTH=4, push 5 codes with no clear.
- Expected delivery: codes 1, 2, 3, then 8'hFF.
REQ-031 Simultaneous push and pop at count=DEPTH: count stays DEPTH, no overflow; wrap of rd_ptr/wr_ptr past 3 checked with DEPTH=4.
REQ-032 Reset: reset_n=0 for 1 edge during OUT_PRESENT with 2 codes queued.
- Expected: all outputs at reset values.
- Expected: no further out_irq until a new in_irq.
